// File: rtl/traffic_phase_ctrl_pkg.sv
// traffic_phase_ctrl_pkg: shared phase encodings, lamp codes, timer width and phase helpers
package traffic_phase_ctrl_pkg;

    localparam int CW         = 7;
    localparam int DEF_GREEN  = 25;
    localparam int DEF_YELLOW = 3;
    localparam int DEF_RED    = 2;
    localparam int DEF_PED    = 5;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_A     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_B     = 3'd5
    } phase_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return RED_A;
            RED_A:     return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            EW_YELLOW: return RED_B;
            default:   return NS_GREEN;
        endcase
    endfunction

    function automatic logic [2:0] ns_lamp(input phase_t p);
        return (p == NS_GREEN) ? LAMP_GRN : (p == NS_YELLOW) ? LAMP_YEL : LAMP_RED;
    endfunction

    function automatic logic [2:0] ew_lamp(input phase_t p);
        return (p == EW_GREEN) ? LAMP_GRN : (p == EW_YELLOW) ? LAMP_YEL : LAMP_RED;
    endfunction

    function automatic logic is_green(input phase_t p);
        return (p == NS_GREEN) || (p == EW_GREEN);
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// phase_timer: loadable down-timer holding the cycles remaining in the current phase
module phase_timer
    import traffic_phase_ctrl_pkg::*;
#(
    parameter logic [CW-1:0] INIT = CW'(DEF_RED)
) (
    input  logic          clk_out,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic [CW-1:0] remaining
);

    // reload on phase entry or truncation, otherwise count down one per tick
    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset)
            remaining <= INIT;
        else
            remaining <= load ? value : remaining - CW'(1);
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: two-road phase sequencer driving lamps and the seconds down-counter load
// Optional pedestrian request logic is built when PED_REQUEST_EN is defined.
module traffic_phase_ctrl
    import traffic_phase_ctrl_pkg::*;
#(
    parameter int T_GREEN  = DEF_GREEN,
    parameter int T_YELLOW = DEF_YELLOW,
    parameter int T_RED    = DEF_RED
`ifdef PED_REQUEST_EN
    ,
    parameter int T_PED    = DEF_PED
`endif
) (
    input  logic          clk_out,
    input  logic          reset,
`ifdef PED_REQUEST_EN
    input  logic          ped_req_n,
`endif
    output logic [CW-1:0] count,
    output logic          load_n,
    output logic [2:0]    ns_light,
    output logic [2:0]    ew_light,
    output logic [2:0]    phase
);

    localparam logic [CW-1:0] LEN_G = CW'(T_GREEN);
    localparam logic [CW-1:0] LEN_Y = CW'(T_YELLOW);
    localparam logic [CW-1:0] LEN_R = CW'(T_RED);

    phase_t        state_q, state_d;
    logic [CW-1:0] remaining, count_d, tmr_val;
    logic          tmr_load, load_n_d, done;

    function automatic logic [CW-1:0] phase_len(input phase_t p);
        return is_green(p) ? LEN_G : (p == NS_YELLOW || p == EW_YELLOW) ? LEN_Y : LEN_R;
    endfunction

    phase_timer #(.INIT(LEN_R)) u_timer (
        .clk_out   (clk_out),
        .reset     (reset),
        .load      (tmr_load),
        .value     (tmr_val),
        .remaining (remaining)
    );

    assign done  = remaining == CW'(1);
    assign phase = state_q;

`ifdef PED_REQUEST_EN
    localparam logic [CW-1:0] LEN_P = CW'(T_PED);

    logic [2:0] ped_sync;
    logic       ped_flag, ped_pending, ped_cut;

    // a request seen this edge acts at once; a flag only survives outside a running green
    assign ped_pending = ped_flag | (ped_sync[2] & ~ped_sync[1]);
    assign ped_cut     = ped_pending & is_green(state_q) & ~done & (remaining > LEN_P);

    // two-stage synchroniser plus edge-history stage and the latched request flag
    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            ped_sync <= 3'b000;
            ped_flag <= 1'b0;
        end else begin
            ped_sync <= {ped_sync[1:0], ped_req_n};
            ped_flag <= ped_pending & ~(is_green(state_q) & ~done);
        end
    end
`endif

    // next phase, timer reload and down-counter strobe; phase end beats a truncation
    always_comb begin
        state_d  = state_q;
        count_d  = count;
        load_n_d = 1'b1;
        tmr_load = 1'b0;
        tmr_val  = phase_len(next_phase(state_q));
        if (done) begin
            state_d  = next_phase(state_q);
            tmr_load = 1'b1;
            count_d  = tmr_val;
            load_n_d = 1'b0;
        end
`ifdef PED_REQUEST_EN
        else if (ped_cut) begin
            tmr_load = 1'b1;
            tmr_val  = LEN_P;
            count_d  = LEN_P;
            load_n_d = 1'b0;
        end
`endif
    end

    // registered state and outputs so lamps never glitch through illegal combinations
    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            state_q  <= RED_B;
            count    <= LEN_R;
            load_n   <= 1'b0;
            ns_light <= LAMP_RED;
            ew_light <= LAMP_RED;
        end else begin
            state_q  <= state_d;
            count    <= count_d;
            load_n   <= load_n_d;
            ns_light <= ns_lamp(state_d);
            ew_light <= ew_lamp(state_d);
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: randomized run/reset bench against a timeline model of the phase cycle
module tb_traffic_phase_ctrl;
    import traffic_phase_ctrl_pkg::*;

    localparam int G = 25, Y = 3, R = 2;

    logic       clk_out = 1'b0;
    logic       reset   = 1'b0;
    logic [6:0] count;
    logic       load_n;
    logic [2:0] ns_light, ew_light, phase;
`ifdef PED_REQUEST_EN
    logic       ped_req_n = 1'b1;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n       = 0;

    traffic_phase_ctrl dut (
        .clk_out   (clk_out),
        .reset     (reset),
`ifdef PED_REQUEST_EN
        .ped_req_n (ped_req_n),
`endif
        .count     (count),
        .load_n    (load_n),
        .ns_light  (ns_light),
        .ew_light  (ew_light),
        .phase     (phase)
    );

    always #5 clk_out = ~clk_out;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t n=%0d: got %0d expected %0d", tag, $time, n, got, exp);
        end
    endtask

    // position k edges after reset release within the 60-cycle timeline starting at RED_B
    function automatic void model(input int k, output int st, output int len, output int ld);
        int seg_len[6] = '{R, G, Y, R, G, Y};
        int seg_st[6]  = '{int'(RED_B), int'(NS_GREEN), int'(NS_YELLOW),
                           int'(RED_A), int'(EW_GREEN), int'(EW_YELLOW)};
        int t = k % (2 * (G + Y + R));
        st = 0; len = 0; ld = 1;
        for (int i = 0; i < 6; i++) begin
            if (t < seg_len[i]) begin
                st = seg_st[i]; len = seg_len[i]; ld = (t == 0) ? 0 : 1;
                return;
            end
            t -= seg_len[i];
        end
    endfunction

    function automatic int ns_of(input int st);
        return (st == int'(NS_GREEN)) ? 1 : (st == int'(NS_YELLOW)) ? 2 : 4;
    endfunction

    function automatic int ew_of(input int st);
        return (st == int'(EW_GREEN)) ? 1 : (st == int'(EW_YELLOW)) ? 2 : 4;
    endfunction

    task automatic tick();
        @(posedge clk_out);
        n++;
        @(negedge clk_out);
    endtask

    task automatic check_cycle();
        int st, len, ld;
        model(n, st, len, ld);
        check("count", int'(count), len);
        check("load_n", int'(load_n), ld);
        check("phase", int'(phase), st);
        check("ns_light", int'(ns_light), ns_of(st));
        check("ew_light", int'(ew_light), ew_of(st));
        check("both_open", int'(ns_light != 3'b100 && ew_light != 3'b100), 0);
        check("onehot", int'($onehot(ns_light) && $onehot(ew_light)), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"}, int'(count), R);
        check({tag, "_load_n"}, int'(load_n), 0);
        check({tag, "_ns"}, int'(ns_light), 4);
        check({tag, "_ew"}, int'(ew_light), 4);
        check({tag, "_phase"}, int'(phase), int'(RED_B));
    endtask

    // assert reset dly after a falling edge (well before the next rising edge), check, release
    task automatic do_reset(input int dly);
        #dly reset = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk_out);
        reset = 1'b1;
        n = 0;
        check_cycle();
    endtask

    task automatic run_to(input int target);
        while (n < target) begin
            tick();
            check_cycle();
        end
    endtask

    initial begin
        int lows;
        repeat (2) @(negedge clk_out);
        check_reset_vals("por");
        reset = 1'b1;
        n = 0;
        check_cycle();
        lows = 0;
        repeat (120) begin
            tick();
            check_cycle();
            if (!load_n) lows++;
        end
        check("load_n_lows_120", lows, 12);
        do_reset(2);
        run_to(40);
        do_reset(2);
        repeat (10) begin
            run_to($urandom_range(1, 150));
            do_reset($urandom_range(1, 3));
        end
`ifdef PED_REQUEST_EN
        do_reset(1);
        run_to(7);
        ped_req_n = 1'b0;
        run_to(9);
        tick();
        check("ped_ns_count", int'(count), 5);
        check("ped_ns_load", int'(load_n), 0);
        ped_req_n = 1'b1;
        tick();
        check("ped_ns_load_hi", int'(load_n), 1);
        repeat (3) tick();
        check("ped_ns_still_grn", int'(ns_light), 1);
        tick();
        check("ped_ns_yel", int'(ns_light), 2);
        check("ped_ns_yel_load", int'(load_n), 0);
        do_reset(1);
        run_to(30);
        ped_req_n = 1'b0;
        run_to(32);
        tick();
        check("ped_ew_count", int'(count), 5);
        check("ped_ew_load", int'(load_n), 0);
        ped_req_n = 1'b1;
        repeat (4) tick();
        check("ped_ew_still_grn", int'(ew_light), 1);
        tick();
        check("ped_ew_yel", int'(ew_light), 2);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
